// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic synth: note indexing and input-stage defaults.
package synth_pkg;

    localparam int unsigned NUM_NOTES               = 12;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;
    localparam int unsigned DEFAULT_MAX_VOICES      = 4;

    // Bit index of each note in key / enable vectors (bit 0 = C).
    typedef enum logic [3:0] {
        NOTE_C, NOTE_CS, NOTE_D, NOTE_DS, NOTE_E, NOTE_F,
        NOTE_FS, NOTE_G, NOTE_GS, NOTE_A, NOTE_AS, NOTE_B
    } note_e;

endpackage

// File: rtl/key_debouncer.sv
// One note key: 2-FF synchroniser followed by a stability counter that
// only accepts a level after it has held for DEBOUNCE_CYCLES cycles.
module key_debouncer
    import synth_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic stable
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= key_raw;
            sync <= meta;
        end
    end

    // Any return to the accepted level restarts the count, so glitches vanish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sync != stable) begin
            if (count == CNT_LAST) begin
                stable <= sync;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/note_key_scanner.sv
// Debounced note keys feeding a bounded voice allocator; drives the mixer
// enable vector plus press/release pulses and an active-voice count.
module note_key_scanner
    import synth_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = NUM_NOTES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned MAX_VOICES      = DEFAULT_MAX_VOICES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] sample_enable,
    output logic                key_pressed,
    output logic                key_released,
    output logic [3:0]          active_count
);

    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] kept;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] grant;
    logic [NUM_KEYS-1:0] new_enable;
    logic [3:0]          kept_count;
    logic [3:0]          new_count;

    function automatic logic [3:0] popcount(input logic [NUM_KEYS-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

    for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk    (clk),
            .reset  (reset),
            .key_raw(keys_in[g]),
            .stable (stable[g])
        );
    end

    // Releases drop at once; at most one new voice (lowest pending index) per cycle.
    always_comb begin
        kept       = sample_enable & stable;
        pending    = stable & ~sample_enable;
        grant      = pending & (~pending + NUM_KEYS'(1));
        kept_count = popcount(kept);
        new_enable = kept;
        if ((kept_count < 4'(MAX_VOICES)) && (pending != '0)) begin
            new_enable = kept | grant;
        end
        new_count = popcount(new_enable);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_enable <= '0;
            key_pressed   <= 1'b0;
            key_released  <= 1'b0;
            active_count  <= '0;
        end else begin
            sample_enable <= new_enable;
            key_pressed   <= (new_enable & ~sample_enable) != '0;
            key_released  <= (sample_enable & ~new_enable) != '0;
            active_count  <= new_count;
        end
    end

endmodule

// File: tb/tb_note_key_scanner.sv
// Directed bench for note_key_scanner with DEBOUNCE_CYCLES=4, MAX_VOICES=4.
module tb_note_key_scanner;

    logic        clk;
    logic        reset;
    logic [11:0] keys_in;
    logic [11:0] sample_enable;
    logic        key_pressed;
    logic        key_released;
    logic [3:0]  active_count;

    int vectors     = 0;
    int miscompares = 0;
    logic any_en;
    logic any_pulse;
    logic [11:0] simul_exp [4];

    note_key_scanner #(
        .NUM_KEYS       (12),
        .DEBOUNCE_CYCLES(4),
        .MAX_VOICES     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .keys_in      (keys_in),
        .sample_enable(sample_enable),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .active_count (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        simul_exp = '{12'h001, 12'h003, 12'h007, 12'h00F};
        reset   = 1'b1;
        keys_in = '0;
        ticks(2);
        check("rst_enable",   sample_enable, 12'h000);
        check("rst_pressed",  12'(key_pressed), 12'h0);
        check("rst_released", 12'(key_released), 12'h0);
        check("rst_count",    12'(active_count), 12'h0);

        // Single press then release
        reset   = 1'b0;
        keys_in = 12'h001;
        ticks(6);
        check("press_e6_enable", sample_enable, 12'h000);
        tick();
        check("press_enable",  sample_enable, 12'h001);
        check("press_pulse",   12'(key_pressed), 12'h1);
        check("press_count",   12'(active_count), 12'h1);
        tick();
        check("press_pulse_off", 12'(key_pressed), 12'h0);
        check("press_hold",      sample_enable, 12'h001);
        keys_in = 12'h000;
        ticks(6);
        check("rel_e6_enable", sample_enable, 12'h001);
        tick();
        check("rel_enable",  sample_enable, 12'h000);
        check("rel_pulse",   12'(key_released), 12'h1);
        check("rel_count",   12'(active_count), 12'h0);
        tick();
        check("rel_pulse_off", 12'(key_released), 12'h0);

        // Glitch of 3 cycles on key 5
        keys_in = 12'h020;
        ticks(3);
        keys_in   = 12'h000;
        any_en    = 1'b0;
        any_pulse = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (sample_enable != '0) any_en = 1'b1;
            if (key_pressed || key_released) any_pulse = 1'b1;
        end
        check("glitch_enable", 12'(any_en), 12'h0);
        check("glitch_pulse",  12'(any_pulse), 12'h0);
        check("glitch_count",  12'(active_count), 12'h0);

        // Simultaneous press of four keys: one grant per cycle, ascending
        keys_in = 12'h00F;
        ticks(6);
        check("simul_e6_enable", sample_enable, 12'h000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("simul_enable%0d", i), sample_enable, simul_exp[i]);
            check($sformatf("simul_pulse%0d", i),  12'(key_pressed), 12'h1);
            check($sformatf("simul_count%0d", i),  12'(active_count), 12'(i + 1));
        end
        tick();
        check("simul_pulse_off", 12'(key_pressed), 12'h0);

        // Voice limit: key 4 pends until key 1 releases
        keys_in = 12'h01F;
        ticks(8);
        check("full_enable", sample_enable, 12'h00F);
        check("full_pulse",  12'(key_pressed), 12'h0);
        check("full_count",  12'(active_count), 12'h4);
        keys_in = 12'h01D;
        ticks(6);
        check("swap_e6_enable", sample_enable, 12'h00F);
        tick();
        check("swap_enable",   sample_enable, 12'h01D);
        check("swap_pressed",  12'(key_pressed), 12'h1);
        check("swap_released", 12'(key_released), 12'h1);
        check("swap_count",    12'(active_count), 12'h4);

        // Back to 00F (key 4 out, key 1 in, same cycle)
        keys_in = 12'h00F;
        ticks(7);
        check("back_enable",   sample_enable, 12'h00F);
        check("back_pressed",  12'(key_pressed), 12'h1);
        check("back_released", 12'(key_released), 12'h1);

        // Release all four together while full
        keys_in = 12'h000;
        ticks(6);
        check("relall_e6_enable", sample_enable, 12'h00F);
        tick();
        check("relall_enable",   sample_enable, 12'h000);
        check("relall_released", 12'(key_released), 12'h1);
        check("relall_pressed",  12'(key_pressed), 12'h0);
        check("relall_count",    12'(active_count), 12'h0);
        tick();
        check("relall_pulse_off", 12'(key_released), 12'h0);

        // Reset two cycles into key 3 debounce
        keys_in = 12'h008;
        ticks(2);
        reset = 1'b1;
        #1;
        check("rstmid_enable", sample_enable, 12'h000);
        check("rstmid_count",  12'(active_count), 12'h0);
        tick();
        reset = 1'b0;
        ticks(6);
        check("rstmid_e6_enable", sample_enable, 12'h000);
        tick();
        check("rstmid_enable_set", sample_enable, 12'h008);
        check("rstmid_pressed",    12'(key_pressed), 12'h1);
        check("rstmid_count_set",  12'(active_count), 12'h1);

        // Reset while a voice is held clears outputs without waiting for an edge
        tick();
        reset = 1'b1;
        #1;
        check("rsthold_enable", sample_enable, 12'h000);
        check("rsthold_count",  12'(active_count), 12'h0);
        tick();
        reset = 1'b0;
        ticks(6);
        check("rsthold_e6_enable", sample_enable, 12'h000);
        tick();
        check("rsthold_enable_set", sample_enable, 12'h008);
        check("rsthold_count_set",  12'(active_count), 12'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_key_scanner.md
# note_key_scanner

Upstream input stage of the polyphonic synth. It synchronises and debounces the 12 raw note pushbuttons and allocates a bounded number of voices. It drives the `sample_enable` vector consumed by `signal_mixer`, so only granted notes are summed into the PWM path. It also reports press/release events and the active-voice count for status LEDs.

## Interface
Parameters:
- `NUM_KEYS`, 12: number of note keys, C..B, bit 0 = C.
- `DEBOUNCE_CYCLES`, 100000: stable-input cycles required to accept a change (10 ms at 10 MHz).
- `MAX_VOICES`, 4: maximum simultaneously enabled notes (1..NUM_KEYS).

Ports:
- `clk`  in  1: system clock (10 MHz domain).
- `reset`  in  1: asynchronous, active-high reset.
- `keys_in`  in  NUM_KEYS: raw pushbuttons, asynchronous, 1 = pressed.
- `sample_enable`  out  NUM_KEYS: granted notes, to `signal_mixer`.
- `key_pressed`  out  1: one-cycle pulse when any `sample_enable` bit rises.
- `key_released`  out  1: one-cycle pulse when any `sample_enable` bit falls.
- `active_count`  out  4: popcount of `sample_enable`.

## Operation
- **Synchronisation:** each `keys_in` bit passes through a 2-FF synchroniser to produce `sync[i]`.
- **Debounce (per key):**
  - Each key has a `stable[i]` register and a counter sized `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync[i] != stable[i]`: the counter increments. When the counter is at `DEBOUNCE_CYCLES-1`, `stable[i] <= sync[i]` and the counter clears.
  - If `sync[i] == stable[i]`: the counter clears. Any glitch shorter than `DEBOUNCE_CYCLES` is discarded.
- **Voice allocation:** all updates are registered, once per cycle.
  - `kept = sample_enable & stable`. Releases drop immediately.
  - `pending = stable & ~sample_enable`.
  - If `popcount(kept) < MAX_VOICES` and `pending != 0`, grant the lowest-index pending bit: `sample_enable <= kept | onehot(lowest pending)`.
  - Otherwise `sample_enable <= kept`.
  - At most one grant per cycle. There is no voice stealing.
  - A key held while voices are full stays pending and is granted as soon as a slot frees. A release and a grant may occur in the same cycle.
- **Events:**
  - `key_pressed` is 1 for one cycle when `new_enable & ~sample_enable != 0`.
  - `key_released` is 1 for one cycle when `sample_enable & ~new_enable != 0`.
  - Both pulses are registered alongside `sample_enable`, so both can be high in the same cycle.
- **`active_count`:** registered popcount of the new enable vector, so it is always consistent with `sample_enable`.

## Timing
- **Reset values:** all outputs 0. Sync FFs, `stable`, and counters are 0.
- **Reset mid-operation:** reset asserted during a debounce or while keys are held clears everything. After release, held keys re-debounce from zero.
- **Press latency:** a raw edge captured at clock edge k gives:
  - `sync` at k+2,
  - `stable` at k+2+DEBOUNCE_CYCLES,
  - `sample_enable` bit and `key_pressed` at k+3+DEBOUNCE_CYCLES, if a voice is free.
- **Release latency:** identical to press latency. The enable bit clears unconditionally.
- **Simultaneous accepted presses (N keys):** grants occur on consecutive cycles in ascending index order, up to `MAX_VOICES` total.
- **Full condition:** `active_count == MAX_VOICES`. No grants occur and pending keys wait.
- **Width rule:** `active_count` saturates by construction (at most `NUM_KEYS` ≤ 15).

## Structure
- **`synth_pkg`:**
  - `NUM_NOTES = 12`.
  - `note_e` enum (C, Cs, D, Ds, E, F, Fs, G, Gs, A, As, B), shared with `frequency_divider`, `oscillator`, and `signal_mixer` indexing.
  - Default `DEBOUNCE_CYCLES`.
- **Sub-module `key_debouncer`:** one key. Contains the 2-FF sync, counter, and `stable` output. Instantiated `NUM_KEYS` times in a generate loop.
- **Top of block:** voice allocator, event pulses, and popcount.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `MAX_VOICES=4`.
- **Single press:** `keys_in[0]` rises at edge 0 and holds. At edge 7, `sample_enable=12'h001`, `key_pressed=1` for one cycle, `active_count=1`. Release gives `sample_enable=0` and `key_released` 7 cycles later.
- **Glitch reject:** `keys_in[5]` high for 3 cycles, then low. `sample_enable` stays 0, no pulses, `active_count=0`.
- **Simultaneous press:** `keys_in=12'h00F` at once. Enables go 001, 003, 007, 00F on four consecutive cycles, each with a `key_pressed` pulse. Final `active_count=4`.
- **Voice limit:** hold `12'h01F`. `sample_enable=12'h00F` and key 4 pends. Release key 1. The cycle after `stable[1]` falls, `sample_enable=12'h01D`, with `key_released` and `key_pressed` both high that cycle.
- **Reset mid-debounce:** assert `reset` 2 cycles after `keys_in[3]` rises, then deassert. All outputs are 0 at once. `sample_enable[3]` sets 7 cycles after reset deasserts.
- **Release during full:** with `12'h00F` enabled, release all four keys together. `sample_enable=0` in one cycle, a single `key_released` pulse, `active_count=0`.
